multdiv_ctrl: RTL and testbench
===============================

# multdiv_ctrl

Multi-cycle sequencer for 32-bit signed multiply and divide in the ALU processor. It accepts a one-cycle command pulse and latches both operands. It runs a fixed 32-iteration shift-add multiply or restoring divide on internal registers, applies the sign correction, then presents the result with a one-cycle ready pulse. It sits beside the single-cycle logic/arith ALU in the execute stage. The pipeline stalls on it from command until `data_resultRDY`.

## Interface
- `WIDTH`, 32: operand/result width; iteration count equals `WIDTH`.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `ctrl_MULT`  in  1  one-cycle pulse; start multiply.
- `ctrl_DIV`  in  1  one-cycle pulse; start divide.
- `data_operandA`  in  WIDTH  multiplicand / dividend, two's complement; sampled on command cycle only.
- `data_operandB`  in  WIDTH  multiplier / divisor, two's complement; sampled on command cycle only.
- `data_result`  out  WIDTH  product low word or quotient; registered.
- `data_exception`  out  1  overflow or divide-by-zero; registered, valid with result.
- `data_resultRDY`  out  1  one-cycle pulse; result and exception valid.
- `busy`  out  1  high from cycle after accepted command through the RDY cycle.

## Operation
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE/DONE plus `ctrl_MULT` leads to MULT; IDLE/DONE plus `ctrl_DIV` leads to DIV. On acceptance, latch |A|, |B|, sign(A)^sign(B), op, and B==0.
- Both ctrl high in the same cycle: MULT wins; DIV is dropped.
- Commands are ignored in MULT, DIV and FIX, with no queuing.
- MULT runs 32 cycles. Each cycle: if the product register LSB is 1, add the multiplicand into the upper half, then shift right. The 64-bit unsigned magnitude product is kept.
- DIV runs 32 cycles of restoring division on magnitudes: shift the remainder left, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
- After 32 iterations, a 6-bit counter moves the FSM to FIX for one cycle.
- FIX negates the result if the sign flag is set, and computes the exception:
  - Multiply: exception when the signed 64-bit true product is outside [-2^31, 2^31-1]. `data_result` is always the low 32 bits of the true signed product.
  - Divide, B==0: `data_result`=0, exception=1.
  - Divide, A=0x80000000 and B=0xFFFFFFFF: `data_result`=0x80000000, exception=1.
  - Divide, otherwise: quotient truncated toward zero; the remainder is discarded; exception=0.
- DONE lasts one cycle with `data_resultRDY`=1, then the FSM goes to IDLE unless a new command is accepted in that same cycle.
- `data_result` and `data_exception` hold until the next FIX cycle.

## Timing
- Command pulse sampled at edge of cycle N.
- MULT/DIV iterations run in cycles N+1..N+32, FIX is cycle N+33, and `data_resultRDY`=1 in cycle N+34 only.
- Latency is a fixed 34 cycles for both ops, including divide-by-zero.
- Back-to-back: a command in cycle N+34 (DONE) is accepted, and its RDY falls in cycle N+68.
- `busy` is high in cycles N+1..N+34. It stays high if DONE accepts a new command.
- Reset, at any time including mid-operation: state IDLE, counter 0, `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0. No RDY pulse follows for the aborted op.
- Operand changes after cycle N have no effect.

## Structure
- Shared package `multdiv_pkg`:
  - state encoding (IDLE, MULT, DIV, FIX, DONE);
  - `MD_WIDTH`=32;
  - `MD_ITER`=32;
  - `MD_INT_MIN`=32'h80000000.
- One sub-module, `multdiv_counter`: 6-bit up-counter with synchronous clear and enable, and a terminal flag at 31.
- Add/subtract uses a local WIDTH+1-bit adder in the controller, not the execute-stage ALU.

## Test plan
- MULT, A=7, B=-6 (0xFFFFFFFA): RDY exactly at N+34, `data_result`=0xFFFFFFD6, exception=0, `busy` high N+1..N+34.
- MULT, A=0x00010000, B=0x00010000: `data_result`=0x00000000, exception=1.
- MULT, A=0x80000000, B=1: `data_result`=0x80000000, exception=0.
- DIV, A=-100, B=7: `data_result`=0xFFFFFFF2 (-14), exception=0.
- DIV, A=5, B=0: `data_result`=0, exception=1, RDY at N+34.
- DIV, A=0x80000000, B=0xFFFFFFFF: `data_result`=0x80000000, exception=1.
- MULT 3×4 starts; `ctrl_DIV` pulse at N+10 is ignored; RDY at N+34 with 12.
- Then `reset` at N+20 of a new op: no RDY, all outputs 0 the cycle after reset. The next MULT 2×3 returns 6 at 34-cycle latency.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
// Imported by the interface, the counter and the controller.
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = 6;

    localparam logic [MD_WIDTH-1:0] MD_INT_MIN = 32'h80000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } md_state_e;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } md_op_e;

endpackage

// File: rtl/multdiv_if.sv
// Command/result bundle between the execute stage and the mult/div sequencer.
// The execute stage is the master; the sequencer is the slave.
interface multdiv_if #(
    parameter int WIDTH = multdiv_pkg::MD_WIDTH
);

    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT,
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  ctrl_MULT,
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY,
        output busy
    );

endinterface

// File: rtl/multdiv_counter.sv
// Iteration counter for the mult/div sequencer.
// Synchronous clear and enable; terminal flag when the count reads MD_ITER-1.
module multdiv_counter
    import multdiv_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_term
);

    logic [MD_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_term = (r_cnt == MD_CNT_W'(MD_ITER - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Multi-cycle signed 32-bit multiply / restoring divide sequencer.
// Works on magnitudes, then applies sign correction and overflow checks in FIX.
module multdiv_ctrl
    import multdiv_pkg::*;
(
    input logic      clock,
    input logic      reset,
    multdiv_if.slave bus
);

    localparam int W = MD_WIDTH;

    md_state_e      r_state;
    md_op_e         r_op;
    logic           r_neg;
    logic           r_bzero;
    logic [W-1:0]   r_opb;
    logic [2*W-1:0] r_prod;
    logic [W-1:0]   r_result;
    logic           r_exc;
    logic           r_rdy;
    logic           r_busy;

    logic           w_start;
    logic           w_is_mul;
    logic           w_iter;
    logic           w_term;
    logic [W-1:0]   w_abs_a;
    logic [W-1:0]   w_abs_b;
    logic [W:0]     w_add_a;
    logic [W:0]     w_add_b;
    logic           w_sub;
    logic [W:0]     w_sum;
    logic           w_nonneg;
    logic [2*W-1:0] w_sprod;
    logic [W-1:0]   w_sq;
    logic [W-1:0]   w_fix_res;
    logic           w_fix_exc;

    assign w_is_mul = bus.ctrl_MULT;
    assign w_start  = ((r_state == ST_IDLE) || (r_state == ST_DONE))
                      && (bus.ctrl_MULT || bus.ctrl_DIV);
    assign w_iter   = (r_state == ST_MULT) || (r_state == ST_DIV);

    assign w_abs_a = bus.data_operandA[W-1] ? -bus.data_operandA
                                            : bus.data_operandA;
    assign w_abs_b = bus.data_operandB[W-1] ? -bus.data_operandB
                                            : bus.data_operandB;

    multdiv_counter u_cnt (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_clear (w_start),
        .i_en    (w_iter),
        .o_term  (w_term)
    );

    // One W+1-bit adder: accumulate for multiply, trial-subtract for divide.
    // For divide, r_prod[2W-1:W-1] is the remainder shifted left by one.
    assign w_sub    = (r_state == ST_DIV);
    assign w_add_a  = w_sub ? r_prod[2*W-1:W-1] : {1'b0, r_prod[2*W-1:W]};
    assign w_add_b  = w_sub ? ~{1'b0, r_opb} : {1'b0, r_opb};
    assign w_sum    = w_add_a + w_add_b + {{W{1'b0}}, w_sub};
    assign w_nonneg = ~w_sum[W];

    assign w_sprod = r_neg ? -r_prod : r_prod;
    assign w_sq    = r_neg ? -r_prod[W-1:0] : r_prod[W-1:0];

    always_comb begin
        w_fix_res = '0;
        w_fix_exc = 1'b0;
        if (r_op == OP_MUL) begin
            w_fix_res = w_sprod[W-1:0];
            w_fix_exc = ~(&w_sprod[2*W-1:W-1] | ~|w_sprod[2*W-1:W-1]);
        end else if (r_bzero) begin
            w_fix_res = '0;
            w_fix_exc = 1'b1;
        end else begin
            // Only INT_MIN / -1 yields a positive 2^31 magnitude quotient.
            w_fix_res = w_sq;
            w_fix_exc = ~r_neg & r_prod[W-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_bzero  <= 1'b0;
            r_opb    <= '0;
            r_prod   <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_busy  <= 1'b1;
                        r_neg   <= bus.data_operandA[W-1]
                                   ^ bus.data_operandB[W-1];
                        r_bzero <= (bus.data_operandB == '0);
                        if (w_is_mul) begin
                            r_state <= ST_MULT;
                            r_op    <= OP_MUL;
                            r_opb   <= w_abs_a;
                            r_prod  <= {{W{1'b0}}, w_abs_b};
                        end else begin
                            r_state <= ST_DIV;
                            r_op    <= OP_DIV;
                            r_opb   <= w_abs_b;
                            r_prod  <= {{W{1'b0}}, w_abs_a};
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_MULT: begin
                    if (r_prod[0]) begin
                        r_prod <= {w_sum, r_prod[W-1:1]};
                    end else begin
                        r_prod <= {1'b0, r_prod[2*W-1:1]};
                    end
                    if (w_term) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_DIV: begin
                    r_prod <= {w_nonneg ? w_sum[W-1:0]
                                        : r_prod[2*W-2:W-1],
                               r_prod[W-2:0], w_nonneg};
                    if (w_term) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result <= w_fix_res;
                    r_exc    <= w_fix_exc;
                    r_rdy    <= 1'b1;
                    r_state  <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = r_busy;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed cases, random ops against a
// plain-arithmetic reference, command-ignore, mid-op reset and back-to-back.
module tb_multdiv_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multdiv_if #(.WIDTH(32)) bus ();

    multdiv_ctrl dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    function automatic void model(input bit is_div,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] r,
                                  output logic e);
        longint sa;
        longint sb;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            r = 32'h80000000;
            e = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
            e = 1'b0;
        end
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'h80000000;
            2: v = 32'hFFFFFFFF;
            3: v = 32'h7FFFFFFF;
            4: v = 32'($urandom_range(0, 255));
            5: v = 32'd0 - 32'($urandom_range(1, 255));
            6: v = 32'($urandom_range(0, 65535)) << $urandom_range(0, 16);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issues one command in cycle N, scrambles operands while the op runs,
    // and expects RDY exactly at N+34 with busy high throughout.
    task automatic run_op(input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b,
                          input string nm);
        logic [31:0] er;
        logic [31:0] r;
        logic        ee;
        logic        e;
        int          lat;
        bit          busy_ok;
        model(!m, a, b, er, ee);
        @(negedge clk);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clk);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        lat = -1;
        busy_ok = 1'b1;
        r = 32'd0;
        e = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            bus.data_operandA = $urandom;
            bus.data_operandB = $urandom;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.data_resultRDY === 1'b1) begin
                lat = k;
                r   = bus.data_result;
                e   = bus.data_exception;
                break;
            end
        end
        n_tests++;
        if (lat !== 34) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected 34", nm, lat);
        end
        n_tests++;
        if (busy_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy: dropped before RDY", nm);
        end
        n_tests++;
        if (r !== er) begin
            n_fail++;
            $display("FAIL %s result: a=%h b=%h got %h expected %h",
                     nm, a, b, r, er);
        end
        n_tests++;
        if (e !== ee) begin
            n_fail++;
            $display("FAIL %s exception: a=%h b=%h got %b expected %b",
                     nm, a, b, e, ee);
        end
        @(negedge clk);
        n_tests++;
        if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: rdy=%b busy=%b expected 0 0",
                     nm, bus.data_resultRDY, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.data_result !== 32'd0 || bus.data_exception !== 1'b0 ||
            bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: res=%h exc=%b rdy=%b busy=%b expected 0",
                     bus.data_result, bus.data_exception,
                     bus.data_resultRDY, bus.busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_mult_directed();
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFA, "mul_7x-6");
        run_op(1'b1, 1'b0, 32'h00010000, 32'h00010000, "mul_ovf");
        run_op(1'b1, 1'b0, 32'h80000000, 32'd1, "mul_intmin");
        run_op(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, "mul_intmin_neg");
    endtask

    task automatic test_div_directed();
        run_op(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7, "div_-100_7");
        run_op(1'b0, 1'b1, 32'd5, 32'd0, "div_by_zero");
        run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_op(1'b0, 1'b1, 32'd3, 32'hFFFFFFFE, "div_3_-2");
    endtask

    task automatic test_both_ctrl();
        run_op(1'b1, 1'b1, 32'd9, 32'd5, "both_ctrl");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        bit          is_div;
        for (int i = 0; i < 24; i++) begin
            a = pick();
            b = pick();
            is_div = 1'($urandom_range(0, 1));
            run_op(!is_div, is_div, a, b, is_div ? "rand_div" : "rand_mul");
        end
    endtask

    task automatic test_ignore();
        int lat;
        logic [31:0] r;
        @(negedge clk);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd4;
        @(negedge clk);
        bus.ctrl_MULT = 1'b0;
        lat = -1;
        r = 32'd0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            bus.ctrl_DIV = (k == 10);
            if (k == 10) begin
                bus.data_operandA = 32'd100;
                bus.data_operandB = 32'd5;
            end
            if (bus.data_resultRDY === 1'b1) begin
                lat = k;
                r   = bus.data_result;
                break;
            end
        end
        bus.ctrl_DIV = 1'b0;
        n_tests++;
        if (lat !== 34) begin
            n_fail++;
            $display("FAIL ignore latency: got %0d expected 34", lat);
        end
        n_tests++;
        if (r !== 32'd12) begin
            n_fail++;
            $display("FAIL ignore result: got %h expected %h", r, 32'd12);
        end
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore idle: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd1234;
        bus.data_operandB = 32'd77;
        @(negedge clk);
        bus.ctrl_MULT = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (bus.data_result !== 32'd0 || bus.data_exception !== 1'b0 ||
            bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: res=%h exc=%b rdy=%b busy=%b expected 0",
                     bus.data_result, bus.data_exception,
                     bus.data_resultRDY, bus.busy);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL midreset quiet: got activity expected none");
        end
        run_op(1'b1, 1'b0, 32'd2, 32'd3, "after_reset_2x3");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1;
        logic [31:0] b1;
        logic [31:0] a2;
        logic [31:0] b2;
        logic [31:0] er1;
        logic [31:0] er2;
        logic        ee1;
        logic        ee2;
        int          lat1;
        int          lat2;
        logic [31:0] r2;
        a1 = pick();
        b1 = pick();
        a2 = $urandom;
        b2 = 32'($urandom_range(1, 1000));
        model(1'b0, a1, b1, er1, ee1);
        model(1'b1, a2, b2, er2, ee2);
        @(negedge clk);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a1;
        bus.data_operandB = b1;
        @(negedge clk);
        bus.ctrl_MULT = 1'b0;
        lat1 = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.data_resultRDY === 1'b1) begin
                lat1 = k;
                break;
            end
        end
        n_tests++;
        if (lat1 !== 34 || bus.data_result !== er1 ||
            bus.data_exception !== ee1) begin
            n_fail++;
            $display("FAIL b2b first: lat=%0d res=%h exc=%b expected 34 %h %b",
                     lat1, bus.data_result, bus.data_exception, er1, ee1);
        end
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = a2;
        bus.data_operandB = b2;
        @(negedge clk);
        bus.ctrl_DIV = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b busy: got %b expected 1", bus.busy);
        end
        lat2 = -1;
        r2 = 32'd0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.data_resultRDY === 1'b1) begin
                lat2 = k;
                r2   = bus.data_result;
                break;
            end
        end
        n_tests++;
        if (lat1 + lat2 !== 68) begin
            n_fail++;
            $display("FAIL b2b second latency: got N+%0d expected N+68",
                     lat1 + lat2);
        end
        n_tests++;
        if (r2 !== er2) begin
            n_fail++;
            $display("FAIL b2b second result: got %h expected %h", r2, er2);
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_both_ctrl();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
